// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux channel with a bounded hold time per owner.
// Grant, mux select and busy are all registered; the select keeps its value while idle.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [1:0]    owner, owner_nx;
  logic [1:0]    last_owner, last_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [3:0]    gnt_nx;
  logic          busy_nx;
  logic [1:0]    winner;
  logic          release_now;

  // First requester found searching upward from base+1; base itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // The owner register doubles as the mux select, so it holds the last owner while idle.
  assign s1 = owner[1];
  assign s0 = owner[0];

  assign winner      = rr_pick(req, (state == GRANT) ? owner : last_owner);
  assign release_now = !req[owner] || (hold == HW'(HOLD_MAX));

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_owner;
    hold_nx  = hold;
    gnt_nx   = gnt;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        hold_nx = '0;
        if (|req) begin
          state_nx = GRANT;
          owner_nx = winner;
          hold_nx  = HW'(1);
          gnt_nx   = 4'b0001 << winner;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_nx = owner;
          // A timed-out owner still requesting alone is re-picked, since it is searched last.
          if (|req) begin
            owner_nx = winner;
            hold_nx  = HW'(1);
            gnt_nx   = 4'b0001 << winner;
          end else begin
            state_nx = IDLE;
            hold_nx  = '0;
            gnt_nx   = 4'b0000;
            busy_nx  = 1'b0;
          end
        end else begin
          hold_nx = hold + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      hold       <= '0;
      gnt        <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      hold       <= hold_nx;
      gnt        <= gnt_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by a long random run,
// compared against a cycle-level behavioural model of the round-robin rules.
module tb_mux_rr_arbiter;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       s1, s0, busy;

  int checks = 0;
  int errors = 0;

  int m_owner;
  int m_last;
  int m_hold;
  int m_sel;
  int waits [4];
  logic [3:0] cur_req;

  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 1; k <= 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
    m_sel   = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  // One rising edge of the arbiter as described by its rules, using integer owner indices.
  task automatic model_update(input logic [3:0] r);
    int w;
    if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin m_owner = w; m_hold = 1; m_sel = w; end
    end else if (!r[m_owner] || m_hold == HOLD) begin
      m_last = m_owner;
      w = pick(r, m_owner);
      if (w >= 0) begin m_owner = w; m_hold = 1; m_sel = w; end
      else begin m_owner = -1; m_hold = 0; end
    end else begin
      m_hold++;
    end
  endtask

  task automatic checkOutput();
    int worst;
    check("gnt", gnt, (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000);
    check("sel", {2'b00, s1, s0}, 4'(m_sel));
    check("busy", {3'b000, busy}, {3'b000, m_owner >= 0});
    check("onehot0", {3'b000, $onehot0(gnt)}, 4'd1);
    check("idx_match", {3'b000, !busy || (gnt == (4'b0001 << {s1, s0}))}, 4'd1);
    worst = 0;
    for (int i = 0; i < 4; i++) begin
      if (cur_req[i] && !gnt[i]) waits[i]++;
      else waits[i] = 0;
      if (waits[i] > worst) worst = waits[i];
    end
    check("starve", {3'b000, worst <= 3 * HOLD}, 4'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    @(negedge clk);
    req = r;
    cur_req = r;
    @(posedge clk);
    model_update(r);
    #1;
    checkOutput();
  endtask

  initial begin
    int exp_owner;
    logic [3:0] r;
    model_reset();
    cur_req = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", {2'b00, s1, s0}, 4'd0);
    check("rst_busy", {3'b000, busy}, 4'd0);
    #1 rst_n = 1'b1;

    // All requesting: owners 0,1,2,3,0 for HOLD cycles each with no idle gap.
    for (int i = 1; i <= 5 * HOLD; i++) begin
      applyStimulus(4'b1111);
      exp_owner = ((i - 1) / HOLD) % 4;
      check("rot_gnt", gnt, 4'b0001 << exp_owner);
      check("rot_sel", {2'b00, s1, s0}, 4'(exp_owner));
    end
    applyStimulus(4'b0000);

    // Short single request, then idle with select held.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100);
      check("short_gnt", gnt, 4'b0100);
    end
    applyStimulus(4'b0000);
    check("idle_gnt", gnt, 4'b0000);
    check("idle_busy", {3'b000, busy}, 4'd0);
    check("idle_sel", {2'b00, s1, s0}, 4'd2);

    // Lone requester keeps the grant across timeouts.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0010);
      check("lone_gnt", gnt, 4'b0010);
    end
    applyStimulus(4'b0000);

    // Owner 2 with 0 and 3 waiting; handoff goes to 3 then 0.
    applyStimulus(4'b0100);
    applyStimulus(4'b1101);
    applyStimulus(4'b1101);
    check("hold2_gnt", gnt, 4'b0100);
    applyStimulus(4'b1001);
    check("hand3_gnt", gnt, 4'b1000);
    applyStimulus(4'b0001);
    check("hand0_gnt", gnt, 4'b0001);
    applyStimulus(4'b0000);

    // Reset mid-grant of owner 1 clears outputs without waiting for an edge.
    for (int i = 0; i < 4; i++) applyStimulus(4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 4'b0000);
    check("async_sel", {2'b00, s1, s0}, 4'd0);
    check("async_busy", {3'b000, busy}, 4'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("inrst_gnt", gnt, 4'b0000);
    #1 rst_n = 1'b1;
    applyStimulus(4'b0010);
    check("postrst_gnt", gnt, 4'b0010);

    // Random requests with slowly toggling bits so timeouts and handoffs both occur.
    r = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      applyStimulus(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, meaning maximum consecutive grant cycles per owner; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 req  input  4  request per requester; bit n requests the shared 4:1 mux channel for input n.
REQ-005 gnt  output  4  one-hot grant; all-zero when no owner.
REQ-006 s1  output  1  mux select MSB; drives s1 of the downstream 4:1 mux.
REQ-007 s0  output  1  mux select LSB; drives s0 of the downstream 4:1 mux.
REQ-008 busy  output  1  high while any grant is active.

Function
REQ-009 All outputs SHALL be registered; no combinational path from req to any output.
REQ-010 FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-011 IDLE -> GRANT SHALL occur on the first edge where req != 0; gnt is valid the cycle after req is sampled (1-cycle latency).
REQ-012 Winner selection SHALL be round-robin: search starts at (last_owner+1) mod 4 and ascends with wrap 3->0; after reset last_owner = 3, so req0 has top priority.
REQ-013 On grant, {s1,s0} SHALL equal the owner index in binary, gnt[owner] = 1, busy = 1, in the same cycle.
REQ-014 hold counter SHALL load 1 on the cycle a grant is issued and increment each further GRANT cycle; width ceil(log2(HOLD_MAX+1)), no wrap.
REQ-015 Owner SHALL release when req[owner] is sampled low, or when hold counter == HOLD_MAX, whichever comes first.
REQ-016 On release with other requests pending, gnt SHALL hand off directly to the next round-robin winner on the next cycle (no IDLE bubble); last_owner updates to the released owner.
REQ-017 On release with no other requests and req[owner] low, FSM SHALL return to IDLE; gnt = 0, busy = 0 next cycle.
REQ-018 On timeout with req[owner] still high and no other requests, the same owner SHALL be re-granted next cycle with hold counter reloaded to 1.
REQ-019 On timeout with other requests pending, the preempted owner SHALL be lowest priority for that selection.
REQ-020 In IDLE, {s1,s0} SHALL hold the last owner's value so the mux output does not glitch.
REQ-021 Requests from non-owners during GRANT SHALL NOT affect gnt until release.
REQ-022 HOLD_MAX = 1 SHALL yield strict per-cycle rotation among active requesters.
REQ-023 gnt SHALL never have more than one bit set; gnt index SHALL always equal {s1,s0} when busy = 1.

Reset
REQ-024 rst_n low SHALL immediately force gnt = 4'b0000, s1 = 0, s0 = 0, busy = 0, FSM = IDLE, hold counter = 0, last_owner = 3.
REQ-025 Reset asserted mid-grant SHALL abort the grant asynchronously; after deassertion the first grant follows REQ-012 from reset priority.
REQ-026 Reset deassertion SHALL be sampled synchronously; first grant no earlier than first rising edge after rst_n high.

Verification
REQ-027 Reset then req = 4'b1111 held -> grant order 0,1,2,3,0 each for exactly 8 cycles; {s1,s0} tracks 00,01,10,11,00; no idle gap between grants.
REQ-028 req = 4'b0100 for 3 cycles then 0 -> gnt = 4'b0100, {s1,s0} = 10 for 3 cycles, then gnt = 0, busy = 0, {s1,s0} stays 10.
REQ-029 Only req[1] held 20 cycles, HOLD_MAX = 8 -> gnt = 4'b0010 continuously, hold counter reloads to 1 at cycles 9 and 17.
REQ-030 Owner 2 active, req[0] and req[3] raised, owner drops req[2] -> next grant to 3, then 0.
REQ-031 rst_n pulsed low at cycle 4 of owner-1 grant -> outputs zero same cycle; after release with req = 4'b0010 -> gnt = 4'b0010 one cycle after first sampled edge.
REQ-032 Random req for 10k cycles -> assertions: gnt one-hot-or-zero, gnt index == {s1,s0} when busy, no owner exceeds HOLD_MAX consecutive cycles while others request, no starvation beyond 3*HOLD_MAX cycles.
